// File: rtl/instr_mem_v_pkg.sv
// Shared constants for the instruction memory: the NOP encoding and the RV32
// opcode/funct fields plus encoders used to build instruction words.
package instr_mem_v_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  localparam logic [2:0] F3_ADD = 3'h0;
  localparam logic [2:0] F3_XOR = 3'h4;
  localparam logic [2:0] F3_OR  = 3'h6;
  localparam logic [2:0] F3_AND = 3'h7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;

  function automatic logic [31:0] encodeIType(input logic [11:0] imm, input logic [4:0] rs1,
                                              input logic [2:0] f3, input logic [4:0] rd,
                                              input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] encodeRType(input logic [6:0] f7, input logic [4:0] rs2,
                                              input logic [4:0] rs1, input logic [2:0] f3,
                                              input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] encodeUType(input logic [19:0] imm, input logic [4:0] rd,
                                              input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

endpackage

// File: rtl/instr_mem_v_if.sv
// Loader and fetch bus of the instruction memory; master is the fetch/loader
// side, slave is the memory.
interface instr_mem_v_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int PC_W   = 32
);

  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              req_valid;
  logic              req_ready;
  logic [PC_W-1:0]   req_pc;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_instr;
  logic [PC_W-1:0]   resp_pc;
  logic              resp_fault;

  modport master (
    output load_en, load_addr, load_data, req_valid, req_pc, flush, resp_ready,
    input  req_ready, resp_valid, resp_instr, resp_pc, resp_fault
  );

  modport slave (
    input  load_en, load_addr, load_data, req_valid, req_pc, flush, resp_ready,
    output req_ready, resp_valid, resp_instr, resp_pc, resp_fault
  );

endinterface

// File: rtl/instr_mem_v_array.sv
// DEPTH x DATA_W storage with synchronous write and a registered synchronous
// read port; words start out as NOP and are never cleared by rst.
module instr_mem_array_v
  import instr_mem_v_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic [$clog2(DEPTH)-1:0]  waddr_i,
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic                      re_i,
  input  logic [$clog2(DEPTH)-1:0]  raddr_i,
  output logic [DATA_W-1:0]         rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: DATA_W'(NOP_INSTR)};
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Non-blocking read returns the pre-write word if both hit one address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= DATA_W'(NOP_INSTR);
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_v.sv
// Fetch-side instruction memory: valid/ready request port, fault decode and a
// one-entry registered response that can be flushed on redirect.
module instr_mem_v
  import instr_mem_v_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int PC_W   = 32
) (
  input  logic          clk,
  input  logic          rst,
  instr_mem_v_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic              reqReady;
  logic              reqAccept;
  logic              reqFault;
  logic [ADDR_W-1:0] reqIndex;
  logic [DATA_W-1:0] readData;

  logic              respValid_q, respValid_d;
  logic [PC_W-1:0]   respPc_q,    respPc_d;
  logic              respFault_q, respFault_d;

  // Loads steal the cycle, and a stalled response blocks new requests.
  assign reqReady  = !bus.load_en && (!respValid_q || bus.resp_ready);
  assign reqAccept = bus.req_valid && reqReady;
  assign reqIndex  = bus.req_pc[ADDR_W+1:2];
  assign reqFault  = (bus.req_pc[1:0] != 2'b00) || ((bus.req_pc >> (ADDR_W + 2)) != '0);

  always_comb begin
    respValid_d = respValid_q;
    respPc_d    = respPc_q;
    respFault_d = respFault_q;
    if (reqAccept) begin
      respValid_d = 1'b1;
      respPc_d    = bus.req_pc;
      respFault_d = reqFault;
    end else if (bus.flush || bus.resp_ready) begin
      respValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      respValid_q <= 1'b0;
      respPc_q    <= '0;
      respFault_q <= 1'b0;
    end else begin
      respValid_q <= respValid_d;
      respPc_q    <= respPc_d;
      respFault_q <= respFault_d;
    end
  end

  instr_mem_array_v #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bus.load_en && !rst),
    .waddr_i (bus.load_addr),
    .wdata_i (bus.load_data),
    .re_i    (reqAccept),
    .raddr_i (reqIndex),
    .rdata_o (readData)
  );

  // Read data and fault flag are both registered, so this mux adds no req->resp path.
  assign bus.req_ready  = reqReady;
  assign bus.resp_valid = respValid_q;
  assign bus.resp_pc    = respPc_q;
  assign bus.resp_fault = respFault_q;
  assign bus.resp_instr = respFault_q ? DATA_W'(NOP_INSTR) : readData;

endmodule

// File: tb/tb_instr_mem_v.sv
// Directed and random checks of instr_mem_v against a word-array model of the
// memory and a behavioural model of the one-entry response slot.
module tb_instr_mem_v;
  import instr_mem_v_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PC_W   = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instr_mem_v_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) bus ();

  instr_mem_v #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mMem [DEPTH];
  bit          mValid;
  logic [31:0] mInstr;
  logic [31:0] mPc;
  bit          mFault;
  bit          mKnown = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit modelFault(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc >= 32'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] randInstr();
    logic [4:0] rd  = 5'($urandom_range(1, 31));
    logic [4:0] rs1 = 5'($urandom_range(0, 31));
    logic [4:0] rs2 = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 5))
      0:       return encodeIType(12'($urandom), rs1, F3_ADD, rd, OPC_OP_IMM);
      1:       return encodeIType(12'($urandom), rs1, F3_XOR, rd, OPC_OP_IMM);
      2:       return encodeIType(12'($urandom), rs1, F3_OR,  rd, OPC_OP_IMM);
      3:       return encodeIType(12'($urandom), rs1, F3_AND, rd, OPC_OP_IMM);
      4:       return encodeRType(($urandom_range(0, 1) == 0) ? F7_BASE : F7_SUB,
                                  rs2, rs1, F3_ADD, rd, OPC_OP);
      default: return encodeUType(20'($urandom), rd, OPC_LUI);
    endcase
  endfunction

  // One clock cycle: drive inputs, check req_ready, advance the model, check resp_*.
  task automatic applyStimulus(input logic r, input logic le, input logic [ADDR_W-1:0] la,
                               input logic [31:0] ld, input logic rv, input logic [31:0] pc,
                               input logic fl, input logic rr, input string tag);
    bit ready;
    bit accept;
    rst           = r;
    bus.load_en   = le;
    bus.load_addr = la;
    bus.load_data = ld;
    bus.req_valid = rv;
    bus.req_pc    = pc;
    bus.flush     = fl;
    bus.resp_ready = rr;
    #1;
    ready  = !le && (!mValid || rr);
    accept = rv && ready;
    if (mKnown) checkOutput({tag, ".req_ready"}, 32'(bus.req_ready), 32'(ready));
    @(posedge clk);
    #1;
    if (r) begin
      mValid = 1'b0;
      mInstr = NOP_INSTR;
      mPc    = '0;
      mFault = 1'b0;
      mKnown = 1'b1;
    end else begin
      if (accept) begin
        mFault = modelFault(pc);
        mInstr = mFault ? NOP_INSTR : mMem[pc / 4];
        mPc    = pc;
        mValid = 1'b1;
      end else if (fl || rr) begin
        mValid = 1'b0;
      end
      if (le) mMem[la] = ld;
    end
    checkOutput({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'(mValid));
    checkOutput({tag, ".resp_instr"}, bus.resp_instr, mInstr);
    checkOutput({tag, ".resp_pc"},    bus.resp_pc,    mPc);
    checkOutput({tag, ".resp_fault"}, 32'(bus.resp_fault), 32'(mFault));
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h00500093;
    prog[1] = 32'h00A00113;
    prog[2] = 32'h002081B3;
    prog[3] = 32'h00000013;
    for (int i = 0; i < DEPTH; i++) mMem[i] = NOP_INSTR;

    $display("[TB] reset and load");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, "reset0");
    applyStimulus(1, 0, 0, 0, 1, 32'h10, 0, 1, "reset1");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, "idle");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, ADDR_W'(i), prog[i], 1, 0, 0, 1, "load");

    $display("[TB] streaming fetch");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 0, 0, 1, 32'(4 * i), 0, 1, "stream");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, "drain0");

    $display("[TB] faults and boundary");
    applyStimulus(0, 0, 0, 0, 1, 32'h6, 0, 1, "misalign");
    applyStimulus(0, 0, 0, 0, 1, 32'(4 * DEPTH), 0, 1, "outOfRange");
    applyStimulus(0, 0, 0, 0, 1, 32'(4 * (DEPTH - 1)), 0, 1, "lastWord");
    applyStimulus(0, 0, 0, 0, 1, 32'h8000_0000, 0, 1, "highBit");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, "drain1");

    $display("[TB] stall, drain and flush");
    applyStimulus(0, 0, 0, 0, 1, 32'h4, 0, 1, "stallAccept");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 0, 1, 32'h8, 0, 0, "stallHold");
    applyStimulus(0, 0, 0, 0, 1, 32'h8, 0, 1, "stallRelease");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "stall8");
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 1, 0, "flushStalled");
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 0, 1, "redirect");
    applyStimulus(0, 0, 0, 0, 1, 32'hC, 1, 1, "flushAccept");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, "flushOnly");

    $display("[TB] load priority and reset mid-stall");
    applyStimulus(0, 1, 5, 32'hDEADBEEF, 1, 32'd20, 0, 1, "loadBlocks");
    applyStimulus(0, 0, 0, 0, 1, 32'd20, 0, 1, "fetchNew");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "holdNew");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "resetStall");
    applyStimulus(0, 0, 0, 0, 1, 32'd20, 0, 1, "memKept");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, "drain2");

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc;
      case ($urandom_range(0, 9))
        7:       pc = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
        8:       pc = 32'(4 * DEPTH + 4 * $urandom_range(0, 100));
        9:       pc = $urandom;
        default: pc = 32'(4 * $urandom_range(0, 15));
      endcase
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0),
                    ADDR_W'($urandom_range(0, 15)), randInstr(),
                    ($urandom_range(0, 3) != 0), pc, ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 2) != 0), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
